branch_predictor: RTL and testbench

//  Parametrised dynamic branch predictor and branch target buffer (BTB) for the pipelined MIPS core.

---
 rtl/branch_pred_pkg.sv | 17 +
 rtl/sat_counter_upd.sv | 22 ++
 rtl/branch_predictor.sv | 117 +++++++++++
 tb/tb_branch_predictor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// rtl/branch_pred_pkg.sv - shared FSM encoding, mode constants and counter init for the branch predictor
package branch_pred_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_t;

  localparam int BIMODAL = 0;
  localparam int GSHARE  = 1;

  // Weakly-not-taken: just below the taken threshold (MSB clear, all lower bits set).
  function automatic int weak_nt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_counter_upd.sv
// rtl/sat_counter_upd.sv - next value of a saturating up/down counter
module sat_counter_upd #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) ctr_next = ctr + CTR_ONE;
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_ONE;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB plus bimodal/gshare pattern table with misprediction flush
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ENTRIES   = 64,
  parameter int CTR_W     = 2,
  parameter int PRED_MODE = BIMODAL,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  output logic [IDX_W-1:0]  pred_hist,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  input  logic [IDX_W-1:0]  ex_hist,
  output logic              flush,
  output logic [ADDR_W-1:0] correct_pc,
  output logic              ready
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'(weak_nt(CTR_W));
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  bp_state_t         state_q, state_d;
  logic [IDX_W-1:0]  sweep_q;
  logic [IDX_W-1:0]  ghr_q;

  logic [IDX_W-1:0]  if_idx, if_pht, ex_idx, ex_pht;
  logic [TAG_W-1:0]  if_tag, ex_tag;
  logic [CTR_W-1:0]  ex_ctr_next;
  logic              hit;
  logic              train;

  function automatic logic [IDX_W-1:0] pht_index(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] hist);
    return (PRED_MODE == GSHARE) ? (idx ^ hist) : idx;
  endfunction

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign if_pht = pht_index(if_idx, ghr_q);
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W+2];
  assign ex_pht = pht_index(ex_idx, ex_hist);

  // Prediction reads pre-update state, so a same-cycle train is seen next cycle.
  assign hit          = ready & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign pred_taken   = hit & ctr_q[if_pht][CTR_W-1];
  assign pred_next_pc = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;
  assign pred_hist    = ghr_q;

  assign flush = ex_valid & ((ex_taken != ex_pred_taken) |
                             (ex_taken & (ex_target != ex_pred_target)));
  assign correct_pc = ex_taken ? ex_target : ex_pc + PC_STEP;

  sat_counter_upd #(.CTR_W(CTR_W)) u_ctr_upd (
    .ctr      (ctr_q[ex_pht]),
    .taken    (ex_taken),
    .ctr_next (ex_ctr_next)
  );

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      ST_INIT: if (sweep_q == LAST_IDX) state_d = ST_RUN;
      default: ready = 1'b1;
    endcase
  end

  assign train = ex_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
      if (train && PRED_MODE == GSHARE) ghr_q <= {ghr_q[IDX_W-2:0], ex_taken};
    end
  end

  // Table contents are cleared by the sweep, not by rst, so storage needs no reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        valid_q[sweep_q] <= 1'b0;
        ctr_q[sweep_q]   <= CTR_INIT;
      end else if (ex_valid) begin
        ctr_q[ex_pht] <= ex_ctr_next;
        if (ex_taken) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed scoreboard bench for bimodal and gshare predictor instances
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [5:0]  ex_hist;

  logic        p0_taken, p0_flush, p0_ready, p1_taken, p1_flush, p1_ready;
  logic [31:0] p0_npc, p0_cpc, p1_npc, p1_cpc;
  logic [5:0]  p0_hist, p1_hist;

  always #5 clk = ~clk;

  branch_predictor #(.PRED_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(p0_taken), .pred_next_pc(p0_npc), .pred_hist(p0_hist),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_hist(ex_hist),
    .flush(p0_flush), .correct_pc(p0_cpc), .ready(p0_ready)
  );

  branch_predictor #(.PRED_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(p1_taken), .pred_next_pc(p1_npc), .pred_hist(p1_hist),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_hist(ex_hist),
    .flush(p1_flush), .correct_pc(p1_cpc), .ready(p1_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [1:0] ctr_m [64];
  logic [5:0] ghr_m;
  logic       btbv_m;
  logic       outcome;
  logic       exp_t_bit;

  task automatic push(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [5:0] hist);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0; ex_hist = hist;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic pred0(input string nm, input logic [31:0] pc, input logic et,
                       input logic [31:0] enpc);
    if_pc = pc;
    push({nm, "_taken"}, {31'b0, et});
    push({nm, "_npc"}, enpc);
    #1;
    check({31'b0, p0_taken});
    check(p0_npc);
  endtask

  task automatic flushchk(input string nm, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptg,
                          input logic ef, input logic [31:0] ecpc);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_target = ptg; ex_hist = 6'd0;
    push({nm, "_flush"}, {31'b0, ef});
    push({nm, "_cpc"}, ecpc);
    #1;
    check({31'b0, p0_flush});
    check(p0_cpc);
    tick();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0;
    ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0; ex_hist = 6'd0;
    tick();
    rst = 1'b0;

    // Init sweep: ready low for exactly 64 cycles, no predictions, no training.
    for (int i = 0; i < 64; i++) begin
      if_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      push("init_ready", 32'd0);
      push("init_pred", 32'd0);
      if (i == 10) begin
        ex_valid = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h140;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h104;
        push("init_flush", 32'd1);
        push("init_cpc", 32'h140);
      end
      #1;
      check({31'b0, p0_ready});
      check({31'b0, p0_taken});
      if (i == 10) begin
        check({31'b0, p0_flush});
        check(p0_cpc);
      end
      tick();
      ex_valid = 1'b0;
    end
    push("ready_after_init", 32'd1);
    #1;
    check({31'b0, p0_ready});
    pred0("no_train_in_init", 32'h100, 1'b0, 32'h104);

    // Bimodal training and saturation on 0x100.
    train(32'h100, 1'b1, 32'h140, 6'd0);
    train(32'h100, 1'b1, 32'h140, 6'd0);
    pred0("bim_trained", 32'h100, 1'b1, 32'h140);
    train(32'h100, 1'b0, 32'h0, 6'd0);
    pred0("bim_one_nt", 32'h100, 1'b1, 32'h140);
    for (int i = 0; i < 5; i++) begin
      train(32'h100, 1'b1, 32'h140, 6'd0);
      pred0("sat_high", 32'h100, 1'b1, 32'h140);
    end
    train(32'h100, 1'b0, 32'h0, 6'd0);
    pred0("sat_3_to_2", 32'h100, 1'b1, 32'h140);
    train(32'h100, 1'b0, 32'h0, 6'd0);
    pred0("sat_2_to_1", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b0, 32'h0, 6'd0);
    train(32'h100, 1'b0, 32'h0, 6'd0);
    pred0("sat_low", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b1, 32'h140, 6'd0);
    pred0("sat_0_to_1", 32'h100, 1'b0, 32'h104);
    train(32'h100, 1'b1, 32'h140, 6'd0);
    pred0("sat_1_to_2", 32'h100, 1'b1, 32'h140);

    // Flush and correction PC.
    flushchk("fl_nt_pred", 32'h1F0, 1'b1, 32'h200, 1'b0, 32'h1F4, 1'b1, 32'h200);
    flushchk("fl_t_pred",  32'h1FC, 1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h200);
    flushchk("fl_correct", 32'h1F0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    flushchk("fl_bad_tgt", 32'h1F0, 1'b1, 32'h200, 1'b1, 32'h240, 1'b1, 32'h200);
    flushchk("fl_nt_ok",   32'h1FC, 1'b0, 32'h300, 1'b0, 32'h200, 1'b0, 32'h200);
    ex_taken = 1'b1; ex_pred_taken = 1'b0;
    push("fl_invalid", 32'd0);
    #1;
    check({31'b0, p0_flush});

    // Same index, different tag: miss, then replacement on taken.
    pred0("alias_miss", 32'h200, 1'b0, 32'h204);
    train(32'h200, 1'b1, 32'h300, 6'd0);
    pred0("alias_old_tag", 32'h100, 1'b0, 32'h104);
    pred0("alias_new_tag", 32'h200, 1'b1, 32'h300);
    pred0("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Same-cycle predict and train: the prediction sees the old state.
    if_pc = 32'h408;
    ex_valid = 1'b1; ex_pc = 32'h408; ex_taken = 1'b1; ex_target = 32'h500;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h40C; ex_hist = 6'd0;
    push("same_cycle_old", 32'd0);
    #1;
    check({31'b0, p0_taken});
    tick();
    ex_valid = 1'b0;
    pred0("same_cycle_new", 32'h408, 1'b1, 32'h500);

    // Gshare: restart from reset, then alternate T,N on 0x100.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (64) tick();
    push("gs_ready", 32'd1);
    #1;
    check({31'b0, p1_ready});
    for (int i = 0; i < 64; i++) ctr_m[i] = 2'd1;
    ghr_m  = 6'd0;
    btbv_m = 1'b0;
    for (int k = 0; k < 16; k++) begin
      outcome   = (k % 2 == 0);
      if_pc     = 32'h100;
      exp_t_bit = btbv_m & ctr_m[ghr_m][1];
      push("gs_hist", {26'b0, ghr_m});
      push("gs_taken", {31'b0, exp_t_bit});
      push("gs_npc", exp_t_bit ? 32'h140 : 32'h104);
      push("bim_hist_zero", 32'd0);
      if (k >= 8) push("gs_alternate", {31'b0, outcome});
      #1;
      check({26'b0, p1_hist});
      check({31'b0, p1_taken});
      check(p1_npc);
      check({26'b0, p0_hist});
      if (k >= 8) check({31'b0, p1_taken});
      train(32'h100, outcome, 32'h140, ghr_m);
      if (outcome && ctr_m[ghr_m] != 2'd3) ctr_m[ghr_m] = ctr_m[ghr_m] + 2'd1;
      else if (!outcome && ctr_m[ghr_m] != 2'd0) ctr_m[ghr_m] = ctr_m[ghr_m] - 2'd1;
      if (outcome) btbv_m = 1'b1;
      ghr_m = {ghr_m[4:0], outcome};
    end
    push("gs_hist_before_rst", {26'b0, ghr_m});
    #1;
    check({26'b0, p1_hist});

    // Mid-operation reset clears GHR, ready and every hit.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_pc = 32'h100;
    push("mid_rst_ready1", 32'd0);
    push("mid_rst_ready0", 32'd0);
    push("mid_rst_hist", 32'd0);
    push("mid_rst_pred", 32'd0);
    #1;
    check({31'b0, p1_ready});
    check({31'b0, p0_ready});
    check({26'b0, p1_hist});
    check({31'b0, p1_taken});
    repeat (64) tick();
    push("post_rst_ready", 32'd1);
    push("post_rst_gs_pred", 32'd0);
    push("post_rst_gs_hist", 32'd0);
    #1;
    check({31'b0, p1_ready});
    check({31'b0, p1_taken});
    check({26'b0, p1_hist});
    pred0("post_rst_bim_cleared", 32'h408, 1'b0, 32'h40C);

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
